// File: rtl/seq_hit_counter.sv
// rtl/seq_hit_counter.sv - windowed rising-edge hit counter for the 110 sequence detector
//
// Counts rising edges of the detector flag over programmable windows of
// clock cycles. Each window total goes into a single-entry valid/ready
// result register. Windows run back-to-back while enable stays high.
//
// Optional feature macro: HIT_SATURATE_EN
//   defined   - accumulator and closing sum saturate at 2^CNT_W-1
//   undefined - accumulator and closing sum wrap modulo 2^CNT_W
//
// Ports:
//   clk       - clock, all state changes on its rising edge
//   reset     - synchronous active-low reset
//   det       - detector flag (sequence detector out)
//   enable    - run measurement windows while high
//   win_len   - window length in cycles, 0 treated as 1, sampled per window
//   cnt_out   - hit count of the last completed window
//   cnt_valid - cnt_out holds an unconsumed result
//   cnt_ready - consumer accepts the result when high with cnt_valid
//   overrun   - sticky, an unconsumed result was overwritten
//   ovr_clr   - clears overrun (a simultaneous set wins)

module seq_hit_counter #(
  parameter int CNT_W = 8,
  parameter int WIN_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             det,
  input  logic             enable,
  input  logic [WIN_W-1:0] win_len,
  output logic [CNT_W-1:0] cnt_out,
  output logic             cnt_valid,
  input  logic             cnt_ready,
  output logic             overrun,
  input  logic             ovr_clr
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state;
  logic             det_q;
  logic [CNT_W-1:0] acc;
  logic [WIN_W-1:0] wc;
  logic [WIN_W-1:0] len;

  logic             hit;
  logic [WIN_W-1:0] win_len_eff;
  logic             closing;
  logic             accept;
  logic             ovr_set;
  logic [CNT_W-1:0] sum;

  always_comb begin
    hit         = det & ~det_q;
    win_len_eff = (win_len == '0) ? WIN_W'(1) : win_len;
    closing     = (state == RUN) && enable && (wc == len - WIN_W'(1));
    accept      = cnt_valid & cnt_ready;
    ovr_set     = closing & cnt_valid & ~cnt_ready;
`ifdef HIT_SATURATE_EN
    // Once the accumulator is all ones a further hit leaves it pinned there.
    sum = (&acc) ? acc : acc + CNT_W'(hit);
`else
    sum = acc + CNT_W'(hit);
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      det_q     <= 1'b0;
      acc       <= '0;
      wc        <= '0;
      len       <= WIN_W'(1);
      cnt_out   <= '0;
      cnt_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      // Edge history runs in every state so a level spanning IDLE->RUN is one hit at most.
      det_q <= det;

      case (state)
        IDLE: begin
          acc <= '0;
          wc  <= '0;
          if (enable) begin
            state <= RUN;
            len   <= win_len_eff;
          end
        end
        RUN: begin
          if (!enable) begin
            // Partial window is dropped; the result register is left alone.
            state <= IDLE;
            acc   <= '0;
            wc    <= '0;
          end else if (closing) begin
            acc <= '0;
            wc  <= '0;
            len <= win_len_eff;
          end else begin
            acc <= sum;
            wc  <= wc + WIN_W'(1);
          end
        end
        default: state <= IDLE;
      endcase

      // A closing cycle loads the new result even when the old one is being
      // accepted in the same cycle, so valid stays high without a gap.
      if (closing) begin
        cnt_out   <= sum;
        cnt_valid <= 1'b1;
      end else if (accept) begin
        cnt_valid <= 1'b0;
      end

      if (ovr_set) begin
        overrun <= 1'b1;
      end else if (ovr_clr) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seq_hit_counter.sv
// tb/tb_seq_hit_counter.sv - directed self-checking bench for seq_hit_counter

module tb_seq_hit_counter;

  logic        clk = 1'b0;
  logic        reset;
  logic        det, enable, cnt_ready, ovr_clr;
  logic [15:0] win_len;
  logic [7:0]  cnt_out;
  logic        cnt_valid, overrun;

  logic        det2, enable2, cnt_ready2, ovr_clr2;
  logic [15:0] win_len2;
  logic [1:0]  cnt_out2;
  logic        cnt_valid2, overrun2;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  seq_hit_counter #(.CNT_W(8), .WIN_W(16)) u_dut (
    .clk(clk), .reset(reset), .det(det), .enable(enable), .win_len(win_len),
    .cnt_out(cnt_out), .cnt_valid(cnt_valid), .cnt_ready(cnt_ready),
    .overrun(overrun), .ovr_clr(ovr_clr)
  );

  seq_hit_counter #(.CNT_W(2), .WIN_W(16)) u_dut_w2 (
    .clk(clk), .reset(reset), .det(det2), .enable(enable2), .win_len(win_len2),
    .cnt_out(cnt_out2), .cnt_valid(cnt_valid2), .cnt_ready(cnt_ready2),
    .overrun(overrun2), .ovr_clr(ovr_clr2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive det from pat[k] during RUN cycle k, for n cycles.
  task automatic run_main(input logic [63:0] pat, input int n);
    for (int k = 0; k < n; k++) begin
      det = pat[k];
      tick();
    end
    det = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; enable = 1'b0; det = 1'b0; cnt_ready = 1'b0; ovr_clr = 1'b0; win_len = 16'd0;
    enable2 = 1'b0; det2 = 1'b0; cnt_ready2 = 1'b0; ovr_clr2 = 1'b0; win_len2 = 16'd0;
    tick(); tick();
    vectors++; if (cnt_out !== 8'd0) begin miscompares++; $display("FAIL reset_cnt_out: got %0d expected 0", cnt_out); end
    vectors++; if (cnt_valid !== 1'b0) begin miscompares++; $display("FAIL reset_cnt_valid: got %b expected 0", cnt_valid); end
    vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
    vectors++; if (cnt_out2 !== 2'd0) begin miscompares++; $display("FAIL reset_cnt_out2: got %0d expected 0", cnt_out2); end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_basic_count();
    win_len = 16'd10; cnt_ready = 1'b1; enable = 1'b1;
    tick();
    run_main(64'b10_0100_1000 >> 1, 10);  // hits in cycles 2, 5, 8
    vectors++; if (cnt_valid !== 1'b1) begin miscompares++; $display("FAIL basic_valid_w1: got %b expected 1", cnt_valid); end
    vectors++; if (cnt_out !== 8'd3) begin miscompares++; $display("FAIL basic_cnt_w1: got %0d expected 3", cnt_out); end
    tick();
    vectors++; if (cnt_valid !== 1'b0) begin miscompares++; $display("FAIL basic_valid_pulse: got %b expected 0", cnt_valid); end
    run_main(64'd0, 9);
    vectors++; if (cnt_valid !== 1'b1) begin miscompares++; $display("FAIL basic_valid_w2: got %b expected 1", cnt_valid); end
    vectors++; if (cnt_out !== 8'd0) begin miscompares++; $display("FAIL basic_cnt_w2: got %0d expected 0", cnt_out); end
    enable = 1'b0;
    tick();
    vectors++; if (cnt_valid !== 1'b0) begin miscompares++; $display("FAIL basic_valid_idle: got %b expected 0", cnt_valid); end
  endtask

  task automatic test_level_filter();
    win_len = 16'd8; enable = 1'b1;
    tick();
    run_main(64'b0111_1000, 8);  // det high cycles 3..6
    vectors++; if (cnt_valid !== 1'b1) begin miscompares++; $display("FAIL level_valid: got %b expected 1", cnt_valid); end
    vectors++; if (cnt_out !== 8'd1) begin miscompares++; $display("FAIL level_cnt: got %0d expected 1", cnt_out); end
    enable = 1'b0;
    tick();
  endtask

  task automatic test_overrun();
    cnt_ready = 1'b0; win_len = 16'd4; enable = 1'b1;
    tick();
    run_main(64'b0010, 4);
    vectors++; if (cnt_out !== 8'd1) begin miscompares++; $display("FAIL ovr_cnt_w1: got %0d expected 1", cnt_out); end
    vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL ovr_flag_w1: got %b expected 0", overrun); end
    run_main(64'b0101, 4);
    vectors++; if (cnt_out !== 8'd2) begin miscompares++; $display("FAIL ovr_cnt_w2: got %0d expected 2", cnt_out); end
    vectors++; if (cnt_valid !== 1'b1) begin miscompares++; $display("FAIL ovr_valid_w2: got %b expected 1", cnt_valid); end
    vectors++; if (overrun !== 1'b1) begin miscompares++; $display("FAIL ovr_flag_w2: got %b expected 1", overrun); end
    enable = 1'b0; ovr_clr = 1'b1;
    tick();
    ovr_clr = 1'b0;
    vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL ovr_clear: got %b expected 0", overrun); end
    vectors++; if (cnt_valid !== 1'b1) begin miscompares++; $display("FAIL ovr_valid_held: got %b expected 1", cnt_valid); end
    vectors++; if (cnt_out !== 8'd2) begin miscompares++; $display("FAIL ovr_cnt_held: got %0d expected 2", cnt_out); end
    cnt_ready = 1'b1;
    tick();
    vectors++; if (cnt_valid !== 1'b0) begin miscompares++; $display("FAIL ovr_accept: got %b expected 0", cnt_valid); end
  endtask

  task automatic test_win_len_zero();
    cnt_ready = 1'b1; win_len = 16'd0; enable = 1'b1;
    tick();
    det = 1'b1;
    tick();
    vectors++; if (cnt_valid !== 1'b1 || cnt_out !== 8'd1) begin miscompares++; $display("FAIL winzero_c0: got valid=%b cnt=%0d expected valid=1 cnt=1", cnt_valid, cnt_out); end
    det = 1'b0;
    tick();
    vectors++; if (cnt_valid !== 1'b1 || cnt_out !== 8'd0) begin miscompares++; $display("FAIL winzero_c1: got valid=%b cnt=%0d expected valid=1 cnt=0", cnt_valid, cnt_out); end
    enable = 1'b0;
    tick();
    vectors++; if (cnt_valid !== 1'b0) begin miscompares++; $display("FAIL winzero_idle: got %b expected 0", cnt_valid); end
  endtask

  task automatic test_back_to_back();
    cnt_ready = 1'b0; win_len = 16'd3; enable = 1'b1;
    tick();
    run_main(64'b001, 3);
    vectors++; if (cnt_valid !== 1'b1 || cnt_out !== 8'd1) begin miscompares++; $display("FAIL collide_w1: got valid=%b cnt=%0d expected valid=1 cnt=1", cnt_valid, cnt_out); end
    run_main(64'b01, 2);
    det = 1'b1; cnt_ready = 1'b1;  // accept on the closing cycle
    tick();
    det = 1'b0;
    vectors++; if (cnt_valid !== 1'b1) begin miscompares++; $display("FAIL collide_valid: got %b expected 1", cnt_valid); end
    vectors++; if (cnt_out !== 8'd2) begin miscompares++; $display("FAIL collide_cnt: got %0d expected 2", cnt_out); end
    vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL collide_overrun: got %b expected 0", overrun); end
    enable = 1'b0;
    tick();
    vectors++; if (cnt_valid !== 1'b0) begin miscompares++; $display("FAIL collide_accept: got %b expected 0", cnt_valid); end
  endtask

  task automatic test_reset_abort();
    cnt_ready = 1'b1; win_len = 16'd10; enable = 1'b1;
    tick();
    run_main(64'b01010, 5);
    reset = 1'b0; enable = 1'b0;
    tick();
    vectors++; if (cnt_out !== 8'd0) begin miscompares++; $display("FAIL rstabort_cnt: got %0d expected 0", cnt_out); end
    vectors++; if (cnt_valid !== 1'b0) begin miscompares++; $display("FAIL rstabort_valid: got %b expected 0", cnt_valid); end
    reset = 1'b1;
    for (int k = 0; k < 8; k++) tick();
    vectors++; if (cnt_valid !== 1'b0) begin miscompares++; $display("FAIL rstabort_no_result: got %b expected 0", cnt_valid); end
  endtask

  task automatic test_enable_abort();
    cnt_ready = 1'b1; win_len = 16'd10; enable = 1'b1;
    tick();
    run_main(64'b01010, 5);
    enable = 1'b0;
    tick();
    for (int k = 0; k < 6; k++) tick();
    vectors++; if (cnt_valid !== 1'b0) begin miscompares++; $display("FAIL enabort_valid: got %b expected 0", cnt_valid); end
    cnt_ready = 1'b0; win_len = 16'd4; enable = 1'b1;
    tick();
    run_main(64'b0001, 4);
    vectors++; if (cnt_valid !== 1'b1 || cnt_out !== 8'd1) begin miscompares++; $display("FAIL enabort_next: got valid=%b cnt=%0d expected valid=1 cnt=1", cnt_valid, cnt_out); end
    enable = 1'b0; cnt_ready = 1'b1;
    tick();
  endtask

  task automatic test_width_limit();
    logic [63:0] pat;
    logic [1:0]  exp_cnt;
    pat = 64'd9362;  // hits in cycles 1, 4, 7, 10, 13
`ifdef HIT_SATURATE_EN
    exp_cnt = 2'd3;
`else
    exp_cnt = 2'd1;
`endif
    cnt_ready2 = 1'b0; win_len2 = 16'd20; enable2 = 1'b1;
    tick();
    for (int k = 0; k < 20; k++) begin
      det2 = pat[k];
      tick();
    end
    det2 = 1'b0; enable2 = 1'b0;
    vectors++; if (cnt_valid2 !== 1'b1) begin miscompares++; $display("FAIL width_valid: got %b expected 1", cnt_valid2); end
    vectors++; if (cnt_out2 !== exp_cnt) begin miscompares++; $display("FAIL width_cnt: got %0d expected %0d", cnt_out2, exp_cnt); end
    tick();
  endtask

  initial begin
    test_reset();
    test_basic_count();
    test_level_filter();
    test_overrun();
    test_win_len_zero();
    test_back_to_back();
    test_reset_abort();
    test_enable_abort();
    test_width_limit();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/seq_hit_counter.md
# seq_hit_counter

Downstream consumer of the 110 sequence detector's `out` flag. Counts detection events (rising edges of the detector output) over a programmable window of clock cycles and presents each window's total through a single-entry valid/ready result register. Gives software or a downstream logger a rate measurement of the detected pattern without sampling the one-cycle detector pulse directly.

## Interface
- `CNT_W`, default 8: width of the hit accumulator and of `cnt_out`.
- `WIN_W`, default 16: width of `win_len`; sets the maximum window length.

- `clk`  in  1: single clock; all state updates on its rising edge.
- `reset`  in  1: synchronous, active-low reset.
- `det`  in  1: detector flag, driven by the sequence detector's `out`.
- `enable`  in  1: run measurement windows while high.
- `win_len`  in  WIN_W: window length in cycles; sampled at each window start.
- `cnt_out`  out  CNT_W: hit count of the last completed window.
- `cnt_valid`  out  1: `cnt_out` holds an unconsumed result.
- `cnt_ready`  in  1: consumer accepts the result when it is high together with `cnt_valid`.
- `overrun`  out  1: sticky flag; an unconsumed result was overwritten.
- `ovr_clr`  in  1: clears `overrun`.

## Operation
- Edge detect: `det_q` register; `hit = det & ~det_q`. A `det` level held high for N cycles counts as 1 hit.
- FSM states:
  - IDLE: accumulator and window counter hold 0.
  - RUN.
- IDLE -> RUN when `enable` = 1. On that edge: latch `L = win_len`, with `win_len` = 0 treated as 1. Clear the accumulator `acc` and the window counter `wc`.
- RUN, `enable` = 1, `wc` < L-1: `acc <= acc + hit`, `wc <= wc + 1`.
- RUN, `enable` = 1, `wc` == L-1 (closing cycle):
  - `cnt_out <= acc + hit`; `cnt_valid <= 1`.
  - `acc <= 0`; `wc <= 0`; re-latch `L` from `win_len`.
  - Stay in RUN, so windows run back-to-back with no gap cycle.
- RUN with `enable` = 0 -> IDLE. The partial `acc` is discarded. `cnt_out`, `cnt_valid` and `overrun` are unaffected.
- Result register:
  - Accept when `cnt_valid` & `cnt_ready`: `cnt_valid <= 0` unless a closing cycle occurs in the same cycle.
  - Closing cycle while `cnt_valid` = 1 and `cnt_ready` = 0: new result overwrites `cnt_out`; `overrun <= 1`.
  - Closing cycle with accept in the same cycle: old result is consumed, new result is loaded, `cnt_valid` stays 1, no overrun.
- `overrun` clears on `ovr_clr` = 1. If a set condition and `ovr_clr` occur in the same cycle, set wins.
- Arithmetic: `acc + hit` is computed at CNT_W width; overflow handling is set under Configuration.
- `cnt_out` is stable while `cnt_valid` = 1, except on an overrun overwrite.

## Timing
- Reset (`reset` = 0 at a rising edge):
  - FSM to IDLE.
  - `acc`, `wc`, `det_q`, `cnt_out` = 0.
  - `cnt_valid` = 0, `overrun` = 0.
- Reset takes effect mid-window with no result emitted.
- Window numbering: RUN cycle 0 is the first cycle after the IDLE->RUN edge. A `hit` present in the cycle where IDLE samples `enable` is not counted.
- Latency: hits from cycles 0..L-1 appear on `cnt_out`, with `cnt_valid` = 1, on the rising edge that ends cycle L-1.
- Result period: exactly L cycles while `enable` stays high.
- `det_q` updates in every state, so the edge history is continuous across IDLE/RUN transitions.

## Configuration
- `HIT_SATURATE_EN` defined: `acc` and the closing sum saturate at 2^CNT_W-1.
- `HIT_SATURATE_EN` undefined: `acc` and the closing sum wrap modulo 2^CNT_W.

## Test plan
- Basic count: reset, `win_len` = 10, `enable` = 1, `cnt_ready` = 1; single-cycle `det` pulses in RUN cycles 2, 5, 8 -> `cnt_valid` pulses for 1 cycle after cycle 9 with `cnt_out` = 3; next window with no hits -> `cnt_out` = 0 at cycle 19.
- Level filtering: `det` held high for RUN cycles 3-6 in a window of `win_len` = 8 -> `cnt_out` = 1.
- Overrun: `win_len` = 4, `cnt_ready` = 0, 1 hit in window 1 and 2 hits in window 2 -> after window 2, `cnt_out` = 2, `cnt_valid` = 1, `overrun` = 1; `ovr_clr` pulse -> `overrun` = 0; `cnt_ready` = 1 -> `cnt_valid` = 0 next cycle.
- Accept/close collision: `cnt_ready` asserted exactly on a closing cycle with `cnt_valid` = 1 -> `cnt_valid` stays 1, new value loaded, `overrun` = 0.
- Width limit: `CNT_W` = 2, `win_len` = 20, 5 separated hits -> `cnt_out` = 3 with `HIT_SATURATE_EN`, `cnt_out` = 1 without it.
- Abort paths: `reset` = 0 at RUN cycle 5 of 10 with 2 hits counted -> all outputs 0, no result emitted; separately, `enable` dropped at cycle 5 -> IDLE, no `cnt_valid`, and the next window counts from 0.
